// File: rtl/pkt_rl_pkg.sv
// Shared state encodings and control-word constants for the packet rate limiter.
package pkt_rl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PASS_HDR,
    ST_PASS_BODY,
    ST_DROP_HDR,
    ST_DROP_BODY
  } state_t;

  localparam logic [7:0] CTRL_HDR  = 8'hFF;
  localparam logic [7:0] CTRL_BODY = 8'h00;
  localparam int         LEN_MSB   = 15;
  localparam int         TOK_W     = 21;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: head word visible on dout whenever !empty.
// nearly_full asserts with one free slot left so a registered upstream can stop in time.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam int CW    = MAX_DEPTH_BITS + 1;

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      do_wr, do_rd;

  assign full        = (cnt_q == CW'(DEPTH));
  assign nearly_full = (cnt_q >= CW'(DEPTH - 1));
  assign empty       = (cnt_q == '0);
  assign dout        = mem_q[rd_ptr_q];
  assign do_wr       = wr_en && !full;
  assign do_rd       = rd_en && !empty;

  always_comb begin
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr && !do_rd) cnt_d = cnt_q + 1'b1;
    if (do_rd && !do_wr) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/pkt_rate_limiter.sv
// Token-bucket packet policer: whole packets pass or drop on the header length; outputs registered (1 cycle).
// Passing waits on out_rdy, dropping drains regardless; PKT_RATE_LIMITER_STATS_EN enables pass/drop counters.
module pkt_rate_limiter
  import pkt_rl_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int PRESCALE   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  cfg_en,
  input  logic [15:0]           cfg_inc,
  input  logic [19:0]           cfg_max,
  output logic [31:0]           pass_cnt,
  output logic [31:0]           drop_cnt
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic                  fifo_empty, fifo_nearly_full, fifo_full, fifo_rd;

  fallthrough_small_fifo #(
    .WIDTH          (CTRL_WIDTH + DATA_WIDTH),
    .MAX_DEPTH_BITS (2)
  ) u_in_fifo (
    .clk         (clk),
    .reset       (reset),
    .din         ({in_ctrl, in_data}),
    .wr_en       (in_wr && !fifo_full),
    .rd_en       (fifo_rd),
    .dout        ({head_ctrl, head_data}),
    .full        (fifo_full),
    .nearly_full (fifo_nearly_full),
    .empty       (fifo_empty)
  );

  assign in_rdy = !fifo_nearly_full;

  state_t                state_q, state_d;
  logic [TOK_W-1:0]      tokens_q, tokens_d;
  logic [PS_W-1:0]       presc_q, presc_d;
  logic                  out_wr_q, out_wr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;

  logic             is_hdr, is_body, admit, fwd, hdr_take, wrap;
  logic [TOK_W-1:0] pkt_len, deduct, refill, tok_sum;

  always_comb begin
    is_hdr   = (head_ctrl == CTRL_WIDTH'(CTRL_HDR));
    is_body  = (head_ctrl == CTRL_WIDTH'(CTRL_BODY));
    pkt_len  = TOK_W'(head_data[LEN_MSB:0]);
    admit    = !cfg_en || (tokens_q >= pkt_len) || (pkt_len == '0);
    fwd      = (state_q == ST_IDLE && is_hdr && admit) ||
               state_q == ST_PASS_HDR || state_q == ST_PASS_BODY;
    // Stray words and dropped packets drain even while downstream stalls.
    fifo_rd  = !fifo_empty && (fwd ? out_rdy : 1'b1);
    hdr_take = (state_q == ST_IDLE) && fifo_rd && is_hdr;

    wrap     = (presc_q == PS_W'(PRESCALE - 1));
    presc_d  = wrap ? '0 : presc_q + 1'b1;
    refill   = wrap ? TOK_W'(cfg_inc) : '0;
    deduct   = (hdr_take && admit && cfg_en) ? pkt_len : '0;
    tok_sum  = tokens_q - deduct + refill;
    tokens_d = (tok_sum > TOK_W'(cfg_max)) ? TOK_W'(cfg_max) : tok_sum;

    state_d = state_q;
    if (fifo_rd) begin
      case (state_q)
        ST_IDLE:      if (is_hdr) state_d = admit ? ST_PASS_HDR : ST_DROP_HDR;
        ST_PASS_HDR:  if (!is_hdr) state_d = is_body ? ST_PASS_BODY : ST_IDLE;
        ST_DROP_HDR:  if (!is_hdr) state_d = is_body ? ST_DROP_BODY : ST_IDLE;
        ST_PASS_BODY,
        ST_DROP_BODY: if (!is_body) state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end

    out_wr_d   = fifo_rd && fwd;
    out_data_d = out_wr_d ? head_data : out_data_q;
    out_ctrl_d = out_wr_d ? head_ctrl : out_ctrl_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tokens_q   <= '0;
      presc_q    <= '0;
      out_wr_q   <= 1'b0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
    end else begin
      state_q    <= state_d;
      tokens_q   <= tokens_d;
      presc_q    <= presc_d;
      out_wr_q   <= out_wr_d;
      out_data_q <= out_data_d;
      out_ctrl_q <= out_ctrl_d;
    end
  end

  assign out_wr   = out_wr_q;
  assign out_data = out_data_q;
  assign out_ctrl = out_ctrl_q;

`ifdef PKT_RATE_LIMITER_STATS_EN
  logic [31:0] pass_cnt_q, pass_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    pass_cnt_d = (hdr_take && admit)  ? pass_cnt_q + 32'd1 : pass_cnt_q;
    drop_cnt_d = (hdr_take && !admit) ? drop_cnt_q + 32'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  assign pass_cnt = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_rate_limiter.sv
// Directed self-checking bench for pkt_rate_limiter (PRESCALE=1, so a refill lands every cycle).
module tb_pkt_rate_limiter;

`ifdef PKT_RATE_LIMITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        cfg_en;
  logic [15:0] cfg_inc;
  logic [19:0] cfg_max;
  logic [31:0] pass_cnt, drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [71:0] cap_q[$];

  pkt_rate_limiter #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .cfg_en(cfg_en), .cfg_inc(cfg_inc), .cfg_max(cfg_max),
    .pass_cnt(pass_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_wr) cap_q.push_back({out_ctrl, out_data});

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    in_wr = 1'b0;
    tick(2);
    reset = 1'b0;
    cap_q.delete();
  endtask

  task automatic send(input logic [7:0] c, input logic [63:0] d);
    int n = 0;
    while (!in_rdy && n < 200) begin
      tick(1);
      n++;
    end
    if (!in_rdy) begin
      checks++; errors++;
      $display("FAIL send_timeout in_rdy=%0b required 1", in_rdy);
    end
    in_ctrl = c; in_data = d; in_wr = 1'b1;
    tick(1);
    in_wr = 1'b0;
  endtask

  task automatic test_reset;
    cfg_en = 1'b1; cfg_inc = 16'd100; cfg_max = 20'd1000; out_rdy = 1'b1;
    reset = 1'b1; in_wr = 1'b0;
    tick(3);
    checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL rst_out_wr got %0b exp 0", out_wr); end
    checks++; if (out_data !== 64'd0 || out_ctrl !== 8'd0) begin errors++; $display("FAIL rst_out_word got %0h/%0h exp 0/0", out_ctrl, out_data); end
    checks++; if (pass_cnt !== 32'd0 || drop_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnts got %0d/%0d exp 0/0", pass_cnt, drop_cnt); end
    checks++; if (dut.tokens_q !== 21'd0) begin errors++; $display("FAIL rst_tokens got %0d exp 0", dut.tokens_q); end
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rst_in_rdy got %0b exp 1", in_rdy); end
    reset = 1'b0;
  endtask

  task automatic test_bypass;
    do_reset;
    cfg_en = 1'b0; cfg_inc = 16'd0; cfg_max = 20'd1000; out_rdy = 1'b1;
    for (int p = 0; p < 3; p++) begin
      send(8'hFF, 64'(100 + p));
      send(8'h00, 64'(p * 16 + 1));
      send(8'h00, 64'(p * 16 + 2));
      send(8'h01, 64'(p * 16 + 3));
    end
    tick(8);
    checks++; if (cap_q.size() != 12) begin errors++; $display("FAIL bypass_words got %0d exp 12", cap_q.size()); end
    checks++; if (pass_cnt !== (STATS ? 32'd3 : 32'd0)) begin errors++; $display("FAIL bypass_pass_cnt got %0d exp %0d", pass_cnt, STATS ? 3 : 0); end
    checks++; if (dut.tokens_q !== 21'd0) begin errors++; $display("FAIL bypass_tokens got %0d exp 0", dut.tokens_q); end
    if (cap_q.size() == 12) begin
      checks++; if (cap_q[11] !== {8'h01, 64'd35}) begin errors++; $display("FAIL bypass_last_word got %0h exp 01_%016h", cap_q[11], 64'd35); end
    end
  endtask

  task automatic test_police;
    do_reset;
    cfg_en = 1'b1; cfg_inc = 16'd100; cfg_max = 20'd1000; out_rdy = 1'b1;
    tick(20);
    cfg_inc = 16'd0;
    checks++; if (dut.tokens_q !== 21'd1000) begin errors++; $display("FAIL police_fill got %0d exp 1000", dut.tokens_q); end
    for (int p = 0; p < 2; p++) begin
      send(8'hFF, 64'd600);
      send(8'h00, 64'(p * 16 + 1));
      send(8'h00, 64'(p * 16 + 2));
      send(8'h01, 64'(p * 16 + 3));
    end
    tick(8);
    checks++; if (cap_q.size() != 4) begin errors++; $display("FAIL police_words got %0d exp 4", cap_q.size()); end
    if (cap_q.size() >= 1) begin
      checks++; if (cap_q[0] !== {8'hFF, 64'd600}) begin errors++; $display("FAIL police_first got %0h exp ff_%016h", cap_q[0], 64'd600); end
    end
    checks++; if (dut.tokens_q !== 21'd400) begin errors++; $display("FAIL police_tokens got %0d exp 400", dut.tokens_q); end
    checks++; if (drop_cnt !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL police_drop_cnt got %0d exp %0d", drop_cnt, STATS ? 1 : 0); end
    checks++; if (pass_cnt !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL police_pass_cnt got %0d exp %0d", pass_cnt, STATS ? 1 : 0); end
  endtask

  task automatic test_zero_len;
    do_reset;
    cfg_en = 1'b1; cfg_inc = 16'd0; cfg_max = 20'd1000; out_rdy = 1'b1;
    send(8'hFF, 64'd0);
    send(8'h01, 64'd7);
    send(8'hFF, 64'd1);
    send(8'h00, 64'd2);
    send(8'h01, 64'd3);
    tick(6);
    checks++; if (cap_q.size() != 2) begin errors++; $display("FAIL zero_len_words got %0d exp 2", cap_q.size()); end
    checks++; if (drop_cnt !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL zero_len_drop got %0d exp %0d", drop_cnt, STATS ? 1 : 0); end
  endtask

  task automatic test_backpressure;
    logic [71:0] exp_w [7];
    exp_w[0] = {8'hFF, 64'd64};
    for (int i = 1; i < 6; i++) exp_w[i] = {8'h00, 64'(32'hA000 + i)};
    exp_w[6] = {8'h01, 64'hA006};
    do_reset;
    cfg_en = 1'b1; cfg_inc = 16'd100; cfg_max = 20'd1000; out_rdy = 1'b1;
    tick(12);
    send(exp_w[0][71:64], exp_w[0][63:0]);
    send(exp_w[1][71:64], exp_w[1][63:0]);
    tick(3);
    out_rdy = 1'b0;
    for (int i = 2; i < 5; i++) send(exp_w[i][71:64], exp_w[i][63:0]);
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_rdy got %0b exp 0", in_rdy); end
    tick(7);
    checks++; if (cap_q.size() != 2) begin errors++; $display("FAIL bp_stall_words got %0d exp 2", cap_q.size()); end
    out_rdy = 1'b1;
    send(exp_w[5][71:64], exp_w[5][63:0]);
    send(exp_w[6][71:64], exp_w[6][63:0]);
    tick(8);
    checks++; if (cap_q.size() != 7) begin errors++; $display("FAIL bp_words got %0d exp 7", cap_q.size()); end
    for (int i = 0; i < 7 && i < cap_q.size(); i++) begin
      checks++; if (cap_q[i] !== exp_w[i]) begin errors++; $display("FAIL bp_word%0d got %0h exp %0h", i, cap_q[i], exp_w[i]); end
    end
  endtask

  task automatic test_refill_deduct;
    do_reset;
    cfg_en = 1'b1; cfg_inc = 16'd20; cfg_max = 20'd60; out_rdy = 1'b1;
    tick(6);
    checks++; if (dut.tokens_q !== 21'd60) begin errors++; $display("FAIL rd_pre_tokens got %0d exp 60", dut.tokens_q); end
    send(8'hFF, 64'd50);
    tick(1);
    checks++; if (dut.tokens_q !== 21'd30) begin errors++; $display("FAIL rd_tokens got %0d exp 30", dut.tokens_q); end
    send(8'h01, 64'd9);
    tick(4);
    checks++; if (cap_q.size() != 2) begin errors++; $display("FAIL rd_words got %0d exp 2", cap_q.size()); end
  endtask

  task automatic test_max_clamp;
    do_reset;
    cfg_en = 1'b1; cfg_inc = 16'd100; cfg_max = 20'd1000; out_rdy = 1'b1;
    tick(12);
    cfg_max = 20'd200;
    tick(1);
    checks++; if (dut.tokens_q !== 21'd200) begin errors++; $display("FAIL clamp_tokens got %0d exp 200", dut.tokens_q); end
  endtask

  task automatic test_mid_reset;
    do_reset;
    cfg_en = 1'b1; cfg_inc = 16'd100; cfg_max = 20'd1000; out_rdy = 1'b1;
    tick(12);
    send(8'hFF, 64'd40);
    send(8'h00, 64'd1);
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++; if (pass_cnt !== 32'd0 || drop_cnt !== 32'd0) begin errors++; $display("FAIL mid_rst_cnts got %0d/%0d exp 0/0", pass_cnt, drop_cnt); end
    cap_q.delete();
    send(8'h00, 64'd2);
    send(8'h01, 64'd3);
    tick(5);
    checks++; if (cap_q.size() != 0) begin errors++; $display("FAIL mid_rst_tail got %0d words exp 0", cap_q.size()); end
    send(8'hFF, 64'd50);
    send(8'h00, 64'd5);
    send(8'h02, 64'd6);
    tick(6);
    checks++; if (cap_q.size() != 3) begin errors++; $display("FAIL mid_rst_next_words got %0d exp 3", cap_q.size()); end
    if (cap_q.size() >= 1) begin
      checks++; if (cap_q[0] !== {8'hFF, 64'd50}) begin errors++; $display("FAIL mid_rst_next_hdr got %0h exp ff_%016h", cap_q[0], 64'd50); end
    end
    checks++; if (pass_cnt !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL mid_rst_pass_cnt got %0d exp %0d", pass_cnt, STATS ? 1 : 0); end
  endtask

  initial begin
    reset = 1'b1; in_wr = 1'b0; in_ctrl = '0; in_data = '0;
    out_rdy = 1'b1; cfg_en = 1'b0; cfg_inc = '0; cfg_max = '0;
    tick(1);
    test_reset;
    test_bypass;
    test_police;
    test_zero_len;
    test_backpressure;
    test_refill_deduct;
    test_max_clamp;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
